// File: rtl/console_pkg.sv
// Shared types and constants for the console write path: field widths,
// glyph codes, control-character values, FSM and cursor-op encodings.
// Optional feature macro: LINE_CLEAR_EN (adds the CLR_ROW state).
package console_pkg;

  localparam int COL_W = 7;
  localparam int ROW_W = 6;

  typedef logic [3:0] glyph_t;
  localparam glyph_t GLYPH_BLANK = 4'hF;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    PUT
`ifdef LINE_CLEAR_EN
    , CLR_ROW
`endif
  } state_t;

  typedef enum logic [2:0] {
    CUR_NOP,
    CUR_ADV,
    CUR_BACK,
    CUR_NL,
    CUR_HOME,
    CUR_LOAD
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // Digits map to their value, A-E / a-e to A-E (both share the low nibble
  // 1..5, so +9 gives A..E); everything else printable shows as blank.
  function automatic glyph_t ascii_to_glyph(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return c[3:0];
    else if ((c >= 8'h41 && c <= 8'h45) || (c >= 8'h61 && c <= 8'h65))
      return c[3:0] + 4'd9;
    else
      return GLYPH_BLANK;
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/col registers. Applies one op per cycle; all wrap handling
// lives here so the cursor can never leave the visible COLS x ROWS area.
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = 100,
  parameter int ROWS = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  cur_op_t          op,
  input  logic [ROW_W-1:0] load_row,
  input  logic [COL_W-1:0] load_col,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             at_eol
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] row_d, row_inc;
  logic [COL_W-1:0] col_d;

  assign at_eol  = (col == COL_MAX);
  assign row_inc = (row == ROW_MAX) ? '0 : row + 1'b1;

  // Next cursor position for the requested op.
  always_comb begin
    row_d = row;
    col_d = col;
    case (op)
      CUR_ADV: begin
        if (at_eol) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col + 1'b1;
        end
      end
      CUR_BACK: begin
        if (col != '0) begin
          col_d = col - 1'b1;
        end else if (row != '0) begin
          col_d = COL_MAX;
          row_d = row - 1'b1;
        end
      end
      CUR_NL: begin
        col_d = '0;
        row_d = row_inc;
      end
      CUR_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      CUR_LOAD: begin
        col_d = load_col;
        row_d = load_row;
      end
      default: ;
    endcase
  end

  // Cursor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_d;
      col <= col_d;
    end
  end

endmodule

// File: rtl/console_writer.sv
// Write-side front end of the character text buffer. Accepts ASCII bytes,
// decodes control characters, drives glyph writes and parks waddr on the
// cursor cell when idle. Optional macro: LINE_CLEAR_EN blanks each new row
// as the cursor moves onto it.
module console_writer
  import console_pkg::*;
#(
  parameter int COLS = 100,
  parameter int ROWS = 37
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        we,
  output logic [12:0] waddr,
  output logic [3:0]  new_char,
  output logic        busy
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  state_t           state, nxt;
  logic             run;
  glyph_t           glyph_q, glyph_d;
  logic             adv_q, adv_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic [COL_W-1:0] clr_col_q, clr_col_d;

  cur_op_t          cop;
  logic [ROW_W-1:0] cur_row, load_row;
  logic [COL_W-1:0] cur_col, load_col;
  logic             at_eol;

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .op       (cop),
    .load_row (load_row),
    .load_col (load_col),
    .row      (cur_row),
    .col      (cur_col),
    .at_eol   (at_eol)
  );

  // State, pending glyph and clear counters. 'run' holds off the first clear
  // write for one cycle so we stays low while reset is asserted and just after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLR_ALL;
      run       <= 1'b0;
      glyph_q   <= GLYPH_BLANK;
      adv_q     <= 1'b0;
      clr_row_q <= '0;
      clr_col_q <= '0;
    end else begin
      state     <= nxt;
      run       <= 1'b1;
      glyph_q   <= glyph_d;
      adv_q     <= adv_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
    end
  end

  // Next-state, cursor ops and buffer-side outputs. Counters always return to
  // zero when a clear finishes, so a later clear starts at column/row 0.
  always_comb begin
    nxt        = state;
    glyph_d    = glyph_q;
    adv_d      = adv_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    cop        = CUR_NOP;
    load_row   = cur_row;
    load_col   = '0;
    char_ready = 1'b0;
    we         = 1'b0;
    waddr      = {cur_row, cur_col};
    new_char   = GLYPH_BLANK;
    busy       = 1'b0;
    case (state)
      CLR_ALL: begin
        busy  = 1'b1;
        we    = run;
        waddr = {clr_row_q, clr_col_q};
        if (run) begin
          if (clr_col_q == COL_MAX) begin
            clr_col_d = '0;
            if (clr_row_q == ROW_MAX) begin
              clr_row_d = '0;
              cop       = CUR_HOME;
              nxt       = IDLE;
            end else begin
              clr_row_d = clr_row_q + 1'b1;
            end
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end
      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          if (is_printable(char_data)) begin
            glyph_d = ascii_to_glyph(char_data);
            adv_d   = 1'b1;
            nxt     = PUT;
          end else begin
            case (char_data)
              ASCII_LF: begin
                cop = CUR_NL;
`ifdef LINE_CLEAR_EN
                nxt = CLR_ROW;
`endif
              end
              ASCII_CR: cop = CUR_LOAD;
              ASCII_BS: begin
                cop     = CUR_BACK;
                glyph_d = GLYPH_BLANK;
                adv_d   = 1'b0;
                nxt     = PUT;
              end
              ASCII_FF: nxt = CLR_ALL;
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        we       = 1'b1;
        new_char = glyph_q;
        nxt      = IDLE;
        if (adv_q) begin
          cop = CUR_ADV;
`ifdef LINE_CLEAR_EN
          if (at_eol) nxt = CLR_ROW;
`endif
        end
      end
`ifdef LINE_CLEAR_EN
      CLR_ROW: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = {cur_row, clr_col_q};
        if (clr_col_q == COL_MAX) begin
          clr_col_d = '0;
          nxt       = IDLE;
        end else begin
          clr_col_d = clr_col_q + 1'b1;
        end
      end
`endif
      default: nxt = CLR_ALL;
    endcase
  end

endmodule
